// File: rtl/instr_enc_pkg.sv
// Shared RV32I encoding constants: instruction classes, opcodes, funct7 values and fixed words.
// Used by the instruction encoder and by the control_unit benches.
package instr_enc_pkg;

    typedef enum logic [3:0] {
        CLS_R      = 4'd0,
        CLS_I      = 4'd1,
        CLS_LOAD   = 4'd2,
        CLS_STORE  = 4'd3,
        CLS_BRANCH = 4'd4,
        CLS_LUI    = 4'd5,
        CLS_AUIPC  = 4'd6,
        CLS_JAL    = 4'd7,
        CLS_JALR   = 4'd8,
        CLS_EBREAK = 4'd9
    } instr_class_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [31:0] NOP_WORD    = 32'h0000_0013;
    localparam logic [31:0] EBREAK_WORD = 32'h0010_0073;

    typedef struct packed {
        logic        err;
        logic [31:0] instr;
    } enc_word_t;

    // Signed range test on a raw 32-bit immediate.
    function automatic logic in_range(input logic [31:0] value, input int lo, input int hi);
        return ($signed(value) >= lo) && ($signed(value) <= hi);
    endfunction

endpackage

// File: rtl/enc_fifo2.sv
// Two-entry valid/ready FIFO holding encoded words with their error flag.
module enc_fifo2
    import instr_enc_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push_valid,
    output logic      push_ready,
    input  enc_word_t push_data,
    output logic      pop_valid,
    input  logic      pop_ready,
    output enc_word_t pop_data
);

    enc_word_t  mem_q [2];
    enc_word_t  mem_d [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       push, pop;

    assign push_ready = (count_q != 2'd2);
    assign pop_valid  = (count_q != 2'd0);
    assign push       = push_valid & push_ready;
    assign pop        = pop_valid & pop_ready;

    // An empty FIFO presents zero so no stale word is visible after a flush.
    assign pop_data = pop_valid ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        count_d  = count_q + {1'b0, push} - {1'b0, pop};
        if (push) begin
            mem_d[wr_ptr_q] = push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: combinational encode and legality check, buffered through a
// two-entry FIFO, with accepted-word and illegal-request counters.
module instr_encoder
    import instr_enc_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_class,
    input  logic [2:0]       in_funct3,
    input  logic             in_alt,
    input  logic [4:0]       in_rd,
    input  logic [4:0]       in_rs1,
    input  logic [4:0]       in_rs2,
    input  logic [31:0]      in_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic             out_err,
    output logic [CNT_W-1:0] word_cnt,
    output logic [7:0]       err_cnt
);

    logic             legal;
    logic [31:0]      word;
    logic [6:0]       f7;
    logic             fits12;
    enc_word_t        enc_word;
    enc_word_t        fifo_out;
    logic             fifo_push_ready;
    logic             accept;
    logic             ready_q, ready_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
    logic [7:0]       err_cnt_q, err_cnt_d;

    assign f7     = in_alt ? F7_ALT : F7_BASE;
    assign fits12 = in_range(in_imm, -2048, 2047);

    always_comb begin
        legal = 1'b0;
        word  = NOP_WORD;
        case (instr_class_e'(in_class))
            CLS_R: begin
                legal = !in_alt || (in_funct3 == 3'b000) || (in_funct3 == 3'b101);
                word  = {f7, in_rs2, in_rs1, in_funct3, in_rd, OPC_R};
            end
            CLS_I: begin
                if ((in_funct3 == 3'b001) || (in_funct3 == 3'b101)) begin
                    legal = (in_imm[31:5] == '0) && (!in_alt || (in_funct3 == 3'b101));
                    word  = {f7, in_imm[4:0], in_rs1, in_funct3, in_rd, OPC_I};
                end else begin
                    legal = fits12;
                    word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_I};
                end
            end
            CLS_LOAD: begin
                legal = (in_funct3 <= 3'b010) && fits12;
                word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, OPC_LOAD};
            end
            CLS_STORE: begin
                legal = (in_funct3 <= 3'b010) && fits12;
                word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], OPC_STORE};
            end
            CLS_BRANCH: begin
                legal = (in_funct3[1] == 1'b0) && (in_funct3 != 3'b010) && (in_funct3 != 3'b011)
                        && !in_imm[0] && in_range(in_imm, -4096, 4094);
                word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                         in_imm[4:1], in_imm[11], OPC_BRANCH};
            end
            CLS_LUI: begin
                legal = (in_imm[11:0] == '0);
                word  = {in_imm[31:12], in_rd, OPC_LUI};
            end
            CLS_AUIPC: begin
                legal = (in_imm[11:0] == '0);
                word  = {in_imm[31:12], in_rd, OPC_AUIPC};
            end
            CLS_JAL: begin
                legal = !in_imm[0] && in_range(in_imm, -1048576, 1048574);
                word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_JAL};
            end
            CLS_JALR: begin
                legal = (in_funct3 == 3'b000) && fits12;
                word  = {in_imm[11:0], in_rs1, 3'b000, in_rd, OPC_JALR};
            end
            CLS_EBREAK: begin
                legal = 1'b1;
                word  = EBREAK_WORD;
            end
            default: begin
                legal = 1'b0;
                word  = NOP_WORD;
            end
        endcase
    end

    assign enc_word.err   = !legal;
    assign enc_word.instr = legal ? word : NOP_WORD;

    // ready_q keeps in_ready low through reset and for the edge that releases it.
    assign in_ready = ready_q & fifo_push_ready;
    assign accept   = in_valid & in_ready;

    enc_fifo2 u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (in_valid & ready_q),
        .push_ready (fifo_push_ready),
        .push_data  (enc_word),
        .pop_valid  (out_valid),
        .pop_ready  (out_ready),
        .pop_data   (fifo_out)
    );

    assign out_instr = fifo_out.instr;
    assign out_err   = fifo_out.err;

    always_comb begin
        ready_d    = 1'b1;
        word_cnt_d = word_cnt_q;
        err_cnt_d  = err_cnt_q;
        if (accept) begin
            word_cnt_d = word_cnt_q + CNT_W'(1);
            if (enc_word.err && (err_cnt_q != 8'hFF)) begin
                err_cnt_d = err_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q    <= 1'b0;
            word_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            ready_q    <= ready_d;
            word_cnt_q <= word_cnt_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign word_cnt = word_cnt_q;
    assign err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a driver pushes reference-model results on acceptance,
// a monitor pops and compares whenever the DUT hands over a word.
module tb_instr_encoder;

    typedef struct {
        int          cls;
        int          f3;
        bit          alt;
        int          rd;
        int          rs1;
        int          rs2;
        logic [31:0] imm;
    } req_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [3:0]  in_class = '0;
    logic [2:0]  in_funct3 = '0;
    logic        in_alt = 1'b0;
    logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
    logic [31:0] in_imm = '0;
    logic        out_ready = 1'b0;

    logic        in_ready, out_valid, out_err;
    logic [31:0] out_instr;
    logic [15:0] word_cnt;
    logic [7:0]  err_cnt;

    logic        in_ready4, out_valid4, out_err4;
    logic [31:0] out_instr4;
    logic [3:0]  word_cnt4;
    logic [7:0]  err_cnt4;

    int          checks = 0;
    int          errors = 0;
    logic [32:0] sb[$];
    int          exp_words = 0;
    int          exp_errs = 0;
    bit          rand_ready = 1'b0;
    bit          hold_valid = 1'b0;
    logic [32:0] hold_word = '0;

    always #5 clk = ~clk;

    instr_encoder #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_funct3(in_funct3), .in_alt(in_alt),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err(out_err), .word_cnt(word_cnt), .err_cnt(err_cnt)
    );

    instr_encoder #(.CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_class(in_class), .in_funct3(in_funct3), .in_alt(in_alt),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .out_valid(out_valid4), .out_ready(out_ready), .out_instr(out_instr4),
        .out_err(out_err4), .word_cnt(word_cnt4), .err_cnt(err_cnt4)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Field placement by arithmetic on the RV32I formats.
    function automatic int unsigned rType(int unsigned f7, int unsigned rs2, int unsigned rs1,
                                          int unsigned f3, int unsigned rd, int unsigned op);
        return (f7 << 25) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
    endfunction

    function automatic int unsigned iType(int unsigned imm, int unsigned rs1, int unsigned f3,
                                          int unsigned rd, int unsigned op);
        return ((imm & 'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | op;
    endfunction

    function automatic logic [32:0] refModel(input req_t r);
        logic [31:0] u;
        int          imm;
        int unsigned w;
        bit          ok, even, fit12;
        u     = r.imm;
        imm   = u;
        even  = (u & 1) == 0;
        fit12 = (imm >= -2048) && (imm <= 2047);
        w     = 0;
        ok    = 1'b0;
        case (r.cls)
            0: begin
                ok = !r.alt || r.f3 == 0 || r.f3 == 5;
                w  = rType(r.alt ? 32 : 0, r.rs2, r.rs1, r.f3, r.rd, 'h33);
            end
            1: begin
                if (r.f3 == 1 || r.f3 == 5) begin
                    ok = (u < 32) && (!r.alt || r.f3 == 5);
                    w  = rType(r.alt ? 32 : 0, u & 31, r.rs1, r.f3, r.rd, 'h13);
                end else begin
                    ok = fit12;
                    w  = iType(u, r.rs1, r.f3, r.rd, 'h13);
                end
            end
            2: begin
                ok = r.f3 <= 2 && fit12;
                w  = iType(u, r.rs1, r.f3, r.rd, 'h03);
            end
            3: begin
                ok = r.f3 <= 2 && fit12;
                w  = (((u >> 5) & 'h7F) << 25) | (r.rs2 << 20) | (r.rs1 << 15) | (r.f3 << 12)
                     | ((u & 'h1F) << 7) | 'h23;
            end
            4: begin
                ok = (r.f3 == 0 || r.f3 == 1 || r.f3 == 4 || r.f3 == 5) && even
                     && imm >= -4096 && imm <= 4094;
                w  = (((u >> 12) & 1) << 31) | (((u >> 5) & 'h3F) << 25) | (r.rs2 << 20)
                     | (r.rs1 << 15) | (r.f3 << 12) | (((u >> 1) & 'hF) << 8)
                     | (((u >> 11) & 1) << 7) | 'h63;
            end
            5, 6: begin
                ok = (u & 'hFFF) == 0;
                w  = (u & 'hFFFFF000) | (r.rd << 7) | ((r.cls == 5) ? 'h37 : 'h17);
            end
            7: begin
                ok = even && imm >= -1048576 && imm <= 1048574;
                w  = (((u >> 20) & 1) << 31) | (((u >> 1) & 'h3FF) << 21) | (((u >> 11) & 1) << 20)
                     | (((u >> 12) & 'hFF) << 12) | (r.rd << 7) | 'h6F;
            end
            8: begin
                ok = r.f3 == 0 && fit12;
                w  = iType(u, r.rs1, 0, r.rd, 'h67);
            end
            9: begin
                ok = 1'b1;
                w  = 'h00100073;
            end
            default: ok = 1'b0;
        endcase
        return ok ? {1'b0, w} : {1'b1, 32'h0000_0013};
    endfunction

    function automatic req_t mkReq(int cls, int f3, bit alt, int rd, int rs1, int rs2, int imm);
        req_t r;
        r.cls = cls; r.f3 = f3; r.alt = alt;
        r.rd = rd; r.rs1 = rs1; r.rs2 = rs2; r.imm = imm;
        return r;
    endfunction

    function automatic req_t randReq();
        int bnd [16] = '{-4097, -4096, -2049, -2048, 2047, 2048, 4094, 4095, 4096,
                         -1048576, 1048574, 1048576, -1048578, 7, 32, 31};
        req_t r;
        r.cls = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
        r.f3  = $urandom_range(0, 7);
        r.alt = ($urandom_range(0, 3) == 0);
        r.rd  = $urandom_range(0, 31);
        r.rs1 = $urandom_range(0, 31);
        r.rs2 = $urandom_range(0, 31);
        case ($urandom_range(0, 5))
            0:       r.imm = $urandom_range(0, 4095) - 2048;
            1:       r.imm = bnd[$urandom_range(0, 15)];
            2:       r.imm = $urandom;
            3:       r.imm = $urandom & 32'hFFFF_F000;
            4:       r.imm = ($urandom_range(0, 4095) - 2048) * 2;
            default: r.imm = $urandom_range(0, 31);
        endcase
        return r;
    endfunction

    // Drive one request and wait for acceptance; the expected word enters the scoreboard then.
    task automatic applyStimulus(input req_t r, input logic [32:0] expected);
        int waited = 0;
        bit done = 1'b0;
        in_class  = 4'(r.cls);
        in_funct3 = 3'(r.f3);
        in_alt    = r.alt;
        in_rd     = 5'(r.rd);
        in_rs1    = 5'(r.rs1);
        in_rs2    = 5'(r.rs2);
        in_imm    = r.imm;
        in_valid  = 1'b1;
        while (!done) begin
            #1;
            if (in_ready) begin
                sb.push_back(expected);
                exp_words++;
                if (expected[32] && exp_errs < 255) exp_errs++;
                done = 1'b1;
            end
            @(negedge clk);
            if (!done) begin
                waited++;
                if (waited > 200) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1");
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic sendReq(input req_t r);
        applyStimulus(r, refModel(r));
    endtask

    task automatic waitDrain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_pending", sb.size(), 0);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        exp_words = 0;
        exp_errs  = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Monitor: compares every handed-over word and checks that a stalled word holds still.
    initial begin
        logic [32:0] exp;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                hold_valid = 1'b0;
            end else begin
                if (hold_valid) begin
                    checkOutput("hold_valid", out_valid, 1);
                    checkOutput("hold_instr", out_instr, hold_word[31:0]);
                    checkOutput("hold_err", out_err, hold_word[32]);
                end
                if (out_valid && out_ready) begin
                    hold_valid = 1'b0;
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_word: got 0x%08h, expected no word", out_instr);
                    end else begin
                        exp = sb.pop_front();
                        checkOutput("out_instr", out_instr, exp[31:0]);
                        checkOutput("out_err", out_err, exp[32]);
                    end
                end else if (out_valid) begin
                    hold_valid = 1'b1;
                    hold_word  = {out_err, out_instr};
                end else begin
                    hold_valid = 1'b0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        errors++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_in_ready", in_ready, 0);
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_out_instr", out_instr, 0);
        checkOutput("rst_out_err", out_err, 0);
        checkOutput("rst_word_cnt", word_cnt, 0);
        checkOutput("rst_err_cnt", err_cnt, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("post_rst_in_ready", in_ready, 1);

        // Directed encodings with hand-derived words.
        out_ready = 1'b1;
        applyStimulus(mkReq(1, 0, 0, 1, 0, 0, 5),           {1'b0, 32'h0050_0093});
        applyStimulus(mkReq(0, 0, 0, 3, 1, 2, 0),           {1'b0, 32'h0020_81B3});
        applyStimulus(mkReq(0, 0, 1, 3, 1, 2, 0),           {1'b0, 32'h4020_81B3});
        applyStimulus(mkReq(3, 2, 0, 0, 1, 2, 8),           {1'b0, 32'h0020_A423});
        applyStimulus(mkReq(4, 0, 0, 0, 1, 2, 8),           {1'b0, 32'h0020_8463});
        applyStimulus(mkReq(5, 0, 0, 5, 0, 0, 'h12345000),  {1'b0, 32'h1234_52B7});
        applyStimulus(mkReq(9, 7, 1, 31, 17, 9, 'hFFFF),    {1'b0, 32'h0010_0073});
        applyStimulus(mkReq(1, 0, 0, 1, 0, 0, 2048),        {1'b1, 32'h0000_0013});
        #1;
        checkOutput("err_cnt_first", err_cnt, 1);
        applyStimulus(mkReq(4, 0, 0, 0, 1, 2, 7),           {1'b1, 32'h0000_0013});
        waitDrain();
        checkOutput("directed_word_cnt", word_cnt, 9);
        checkOutput("directed_err_cnt", err_cnt, 2);

        // Backpressure: two words fill the FIFO, the third stalls until out_ready returns.
        doReset();
        out_ready = 1'b0;
        sendReq(mkReq(1, 0, 0, 1, 0, 0, 11));
        sendReq(mkReq(0, 4, 0, 7, 8, 9, 0));
        #1;
        checkOutput("full_in_ready", in_ready, 0);
        fork
            sendReq(mkReq(2, 2, 0, 4, 5, 0, -16));
            begin
                repeat (3) @(negedge clk);
                #2;
                checkOutput("stall_word_cnt", word_cnt, 2);
                out_ready = 1'b1;
            end
        join
        waitDrain();
        checkOutput("bp_word_cnt", word_cnt, 3);

        // Reset with two words queued discards them at once.
        out_ready = 1'b0;
        sendReq(mkReq(7, 0, 0, 1, 0, 0, 2048));
        sendReq(mkReq(8, 0, 0, 1, 2, 0, -4));
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        exp_words = 0;
        exp_errs  = 0;
        #1;
        checkOutput("mid_rst_out_valid", out_valid, 0);
        checkOutput("mid_rst_word_cnt", word_cnt, 0);
        checkOutput("mid_rst_err_cnt", err_cnt, 0);
        checkOutput("mid_rst_out_instr", out_instr, 0);
        checkOutput("mid_rst_in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        checkOutput("no_stale_word", out_valid, 0);

        // Error-counter saturation and narrow word-counter wrap.
        for (int i = 1; i <= 256; i++) begin
            sendReq(mkReq(10 + (i % 6), i % 8, 0, i % 32, 0, 0, i));
            if (i == 15) checkOutput("wrap4_at_15", word_cnt4, 15);
            if (i == 16) checkOutput("wrap4_at_16", word_cnt4, 0);
            if (i == 255) checkOutput("err_cnt_255", err_cnt, 255);
        end
        waitDrain();
        checkOutput("err_cnt_sat", err_cnt, 255);
        checkOutput("sat_word_cnt", word_cnt, 256);

        // Randomized requests with random consumer backpressure.
        doReset();
        rand_ready = 1'b1;
        repeat (300) sendReq(randReq());
        @(negedge clk);
        rand_ready = 1'b0;
        out_ready  = 1'b1;
        waitDrain();
        checkOutput("rand_word_cnt", word_cnt, 32'(exp_words) & 32'hFFFF);
        checkOutput("rand_err_cnt", err_cnt, exp_errs);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
